// File: rtl/gpu_pkg.sv
// Shared GPU block definitions: default coordinate widths, the line
// scheduler FSM encoding and the line-draw opcode used by command decode.
package gpu_pkg;

    localparam int XW_DEF = 9;
    localparam int YW_DEF = 8;

    localparam logic [2:0] OP_LINE = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_START,
        S_DRAW,
        S_DONE
    } lsched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts one above the last
// winner and wraps, so the previous owner has the lowest priority.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id
);

    logic found;

    // Scan last+1 .. last+NREQ (mod NREQ); the first active request wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && req[(int'(last) + i) % NREQ]) begin
                found = 1'b1;
                grant[(int'(last) + i) % NREQ] = 1'b1;
                grant_id = IDW'((int'(last) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/line_cmd_sched.sv
// Shares the single line-drawing engine among NREQ command sources.
// One command at a time: grant, capture, launch, stream pixels to the
// framebuffer tagged with the owner ID, then report completion. A watchdog
// aborts a line when the engine goes silent for TIMEOUT DRAW cycles.
module line_cmd_sched
    import gpu_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int XW      = XW_DEF,
    parameter  int YW      = YW_DEF,
    parameter  int TIMEOUT = 1023,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    // requester side
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*XW-1:0]     req_x1,
    input  logic [NREQ*XW-1:0]     req_x2,
    input  logic [NREQ*YW-1:0]     req_y1,
    input  logic [NREQ*YW-1:0]     req_y2,
    // engine side
    output logic                   eng_start,
    output logic signed [XW-1:0]   eng_x1,
    output logic signed [XW-1:0]   eng_x2,
    output logic signed [YW-1:0]   eng_y1,
    output logic signed [YW-1:0]   eng_y2,
    input  logic                   eng_pix_valid,
    input  logic signed [XW-1:0]   eng_x,
    input  logic signed [YW-1:0]   eng_y,
    input  logic                   eng_last,
    output logic                   eng_pix_ready,
    // framebuffer write port
    output logic                   pix_valid,
    output logic signed [XW-1:0]   pix_x,
    output logic signed [YW-1:0]   pix_y,
    output logic [IDW-1:0]         pix_id,
    input  logic                   pix_ready,
    // completion / status
    output logic                   done_valid,
    output logic [IDW-1:0]         done_id,
    output logic                   done_err,
    output logic                   busy,
    output logic                   err_timeout
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    lsched_state_t         state;
    logic [IDW-1:0]        last;
    logic [IDW-1:0]        gnt_id;
    logic [IDW-1:0]        owner;
    logic [WDW-1:0]        wdog;

    logic [NREQ-1:0]       arb_grant;
    logic [IDW-1:0]        arb_id;

    logic signed [XW-1:0]  sel_x1, sel_x2;
    logic signed [YW-1:0]  sel_y1, sel_y2;

    logic                  drawing;
    logic                  xfer;
    logic                  wd_expire;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req      (req_valid),
        .last     (last),
        .grant    (arb_grant),
        .grant_id (arb_id)
    );

    // Pixel path is a straight pass-through, only opened while drawing.
    assign drawing       = (state == S_DRAW);
    assign pix_valid     = drawing & eng_pix_valid;
    assign eng_pix_ready = drawing & pix_ready;
    assign pix_x         = eng_x;
    assign pix_y         = eng_y;
    assign pix_id        = owner;
    assign done_id       = owner;
    assign xfer          = pix_valid & pix_ready;

    // Expire on the silent cycle that would bring the count to TIMEOUT.
    assign wd_expire = drawing && !eng_pix_valid && (wdog == WDW'(TIMEOUT - 1));

    // Route the granted requester's coordinate slices to the capture regs.
    always_comb begin
        sel_x1 = '0;
        sel_x2 = '0;
        sel_y1 = '0;
        sel_y2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                sel_x1 = req_x1[i*XW +: XW];
                sel_x2 = req_x2[i*XW +: XW];
                sel_y1 = req_y1[i*YW +: YW];
                sel_y2 = req_y2[i*YW +: YW];
            end
        end
    end

    // Watchdog: counts silent engine cycles in DRAW; a framebuffer stall
    // with a pixel pending is not silence, so it clears the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wdog <= '0;
        else if (state == S_START)
            wdog <= '0;
        else if (drawing)
            wdog <= eng_pix_valid ? '0 : wdog + WDW'(1);
    end

    // Sequencer: arbitrate, capture, launch, stream, report.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            last        <= IDW'(NREQ - 1);
            gnt_id      <= '0;
            owner       <= '0;
            eng_x1      <= '0;
            eng_x2      <= '0;
            eng_y1      <= '0;
            eng_y2      <= '0;
            req_ready   <= '0;
            eng_start   <= 1'b0;
            done_valid  <= 1'b0;
            done_err    <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            req_ready  <= '0;
            eng_start  <= 1'b0;
            done_valid <= 1'b0;
            done_err   <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        gnt_id    <= arb_id;
                        req_ready <= arb_grant;
                        busy      <= 1'b1;
                        state     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    eng_x1    <= sel_x1;
                    eng_x2    <= sel_x2;
                    eng_y1    <= sel_y1;
                    eng_y2    <= sel_y2;
                    owner     <= gnt_id;
                    eng_start <= 1'b1;
                    state     <= S_START;
                end
                S_START: begin
                    state <= S_DRAW;
                end
                S_DRAW: begin
                    if (xfer && eng_last) begin
                        done_valid <= 1'b1;
                        state      <= S_DONE;
                    end else if (wd_expire) begin
                        done_valid  <= 1'b1;
                        done_err    <= 1'b1;
                        err_timeout <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    last  <= owner;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/line_cmd_sched.md
# line_cmd_sched

Round-robin scheduler that shares the single line-drawing engine among `NREQ` command sources (CPU queue, rasteriser, overlay, etc.). Each requester submits a line command `(x1,y1)->(x2,y2)`. The block grants the engine to one requester at a time, launches it, forwards its pixel stream to the framebuffer write port with the owner's ID, and reports completion. A watchdog guards against a hung engine.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `XW`, 9: signed x coordinate width.
- `YW`, 8: signed y coordinate width.
- `TIMEOUT`, 1023: max consecutive DRAW cycles with no engine pixel before abort.
- `IDW`, derived, `$clog2(NREQ)`: requester ID width.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in NREQ: per-requester command valid; must hold until `req_ready`.
- `req_ready` out NREQ: one-hot accept, one cycle.
- `req_x1`, `req_x2` in NREQ*XW: packed signed start/end x; slice i belongs to requester i.
- `req_y1`, `req_y2` in NREQ*YW: packed signed start/end y.
- `eng_start` out 1: one-cycle launch pulse to the engine.
- `eng_x1`, `eng_x2` out XW: registered command to the engine.
- `eng_y1`, `eng_y2` out YW: registered command to the engine.
- `eng_pix_valid` in 1: engine pixel valid.
- `eng_x` in XW: engine pixel x.
- `eng_y` in YW: engine pixel y.
- `eng_last` in 1: marks the final pixel of the line.
- `eng_pix_ready` out 1: backpressure to the engine.
- `pix_valid` out 1: framebuffer write request.
- `pix_x` out XW: framebuffer write x.
- `pix_y` out YW: framebuffer write y.
- `pix_id` out IDW: ID of the requester that owns the pixel.
- `pix_ready` in 1: framebuffer accepts the write.
- `done_valid` out 1: one-cycle completion pulse.
- `done_id` out IDW: requester that completed.
- `done_err` out 1: qualifies `done_valid`; set on timeout abort.
- `busy` out 1: high whenever state is not IDLE.
- `err_timeout` out 1: sticky; cleared only by reset.

## Operation
- FSM states: IDLE, GRANT, START, DRAW, DONE.
- IDLE: if any `req_valid`, pick winner `g` by round-robin and go to GRANT. Otherwise stay.
- Round-robin: the search starts at `last+1` mod NREQ. After reset `last = NREQ-1`, so requester 0 has the highest priority first.
- GRANT: `req_ready[g]=1` for exactly this cycle. Capture slice `g` of the coordinates into the `eng_*` registers and `g` into `owner`. Go to START.
- START: `eng_start=1` for one cycle. Clear the watchdog. Go to DRAW.
- DRAW: the pixel path is combinational pass-through.
  - `pix_valid=eng_pix_valid`, `pix_x/pix_y=eng_x/eng_y`, `pix_id=owner`, `eng_pix_ready=pix_ready`.
  - Transfer occurs when `eng_pix_valid & pix_ready`.
  - A transfer with `eng_last=1` goes to DONE.
- Watchdog: counts DRAW cycles with `eng_pix_valid=0` and resets on any `eng_pix_valid`. Stalls caused by `pix_ready=0` do not count.
- Timeout: when the count reaches TIMEOUT, set `err_timeout`, set `done_err` for the DONE cycle, and go to DONE.
- DONE: `done_valid=1`, `done_id=owner`. Set `last=owner`. Go to IDLE.
- Outside DRAW: `pix_valid=0` and `eng_pix_ready=0`.
- Degenerate line (x1==x2, y1==y2): the engine emits one pixel with `eng_last=1`; handled normally.
- No arithmetic on coordinates; widths pass through unchanged and stay signed.

## Timing
- Reset values (asynchronous):
  - state IDLE, `last=NREQ-1`, watchdog 0.
  - `eng_x1/x2/y1/y2`, `owner` all 0.
  - All outputs 0: `req_ready`, `eng_start`, `pix_valid`, `done_valid`, `done_err`, `busy`, `err_timeout`.
- Request with `req_valid` first seen in IDLE at cycle N:
  - `req_ready` at N+1.
  - `eng_start` at N+2.
  - DRAW from N+3.
- Last pixel accepted at cycle M: `done_valid` at M+1. The next grant `req_ready` comes at M+3 at the earliest.
- Requests arriving during a busy period wait; there is no queueing beyond the held `req_valid`.
- Withdrawing `req_valid` before `req_ready` is illegal; the bench asserts against it.
- Reset mid-DRAW: returns to IDLE with no `done_valid` for the aborted line. The engine is reset by the same `reset`.
- `eng_last` on a non-accepted cycle (`pix_ready=0`) does not end DRAW.

## Structure
- Shared package `gpu_pkg`: XW/YW defaults, the FSM state enum `lsched_state_t`, and the `OP_LINE=3'b100` opcode constant used by top-level decode.
- One sub-module, `rr_arbiter`:
  - Parameter NREQ.
  - Inputs: `req`, `last`.
  - Outputs: one-hot `grant`, binary `grant_id`.
  - Purely combinational.
- The FSM, watchdog and command registers live in `line_cmd_sched`.

## Test plan
- Single request: requester 1 sends (0,0)->(3,3); the engine model emits 4 pixels, last on the 4th. Expect `req_ready[1]` at N+1, `eng_start` at N+2, four `pix_valid` with `pix_id=1`, then `done_valid`, `done_id=1`, `done_err=0`.
- Fairness: all 4 requesters hold `req_valid` continuously for 8 commands. Expect grant order 0,1,2,3,0,1,2,3.
- Backpressure: `pix_ready` toggles 1,0,0,1 during a line (-5,-2)->(-1,2). Expect every pixel delivered exactly once, in order, with x/y signs preserved. Expect no `err_timeout` even with `pix_ready` held low for 2000 cycles.
- Timeout: engine never asserts `eng_pix_valid` after `eng_start`. Expect `done_valid` with `done_err=1` exactly 1023 DRAW cycles later. `err_timeout` stays high until reset, and the next request is then still served.
- Degenerate line: (7,7)->(7,7). Expect one pixel (7,7) with `eng_last`, then `done_valid`.
- Reset mid-DRAW: assert `reset` for one cycle after the 2nd pixel. Expect all outputs 0 asynchronously, no `done_valid`, and requester 0 winning next among simultaneous requests 0 and 2.
